// File: rtl/battleship_board_if.sv
// Control/status bundle between the cursor/button logic, the game-state block and the renderer.
interface battleship_board_if #(
    parameter int unsigned GRID_N = 10,
    parameter int unsigned ID_W   = 3,
    parameter int unsigned TURN_W = 5
);
    logic                         place_valid;
    logic [3:0]                   place_row;
    logic [3:0]                   place_col;
    logic [ID_W-1:0]              place_id;
    logic                         start;
    logic                         new_game;
    logic                         fire;
    logic [3:0]                   sprite_row;
    logic [3:0]                   sprite_col;
    logic                         place_err;
    logic [2*GRID_N*GRID_N-1:0]   cell_status_flat;
    logic [TURN_W-1:0]            turns_left;
    logic [ID_W-1:0]              ships_left;
    logic                         shot_valid;
    logic [1:0]                   shot_code;
    logic                         busy;
    logic                         game_over;
    logic                         win;

    modport master (
        output place_valid, place_row, place_col, place_id, start, new_game, fire,
               sprite_row, sprite_col,
        input  place_err, cell_status_flat, turns_left, ships_left, shot_valid, shot_code,
               busy, game_over, win
    );

    modport slave (
        input  place_valid, place_row, place_col, place_id, start, new_game, fire,
               sprite_row, sprite_col,
        output place_err, cell_status_flat, turns_left, ships_left, shot_valid, shot_code,
               busy, game_over, win
    );
endinterface

// File: rtl/battleship_board.sv
// Parametrised battleship game state: run-time ship placement, shot resolution,
// per-ship sunk sweep and win/lose tracking.
module battleship_board #(
    parameter int unsigned GRID_N    = 10,
    parameter int unsigned MAX_SHIPS = 5,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned TURNS     = 15,
    parameter int unsigned TURN_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    battleship_board_if.slave  bus
);
    localparam int unsigned NCELL = GRID_N * GRID_N;
    localparam int unsigned CNT_W = $clog2(NCELL + 1);
    localparam int unsigned IDX_W = $clog2(NCELL);
    localparam int unsigned NID   = 2 ** ID_W;
    localparam logic [3:0]      GRID_N4 = 4'(GRID_N);
    localparam logic [ID_W-1:0] MAX_ID  = ID_W'(MAX_SHIPS);

    typedef enum logic [2:0] {S_LOAD, S_PLAY, S_SWEEP, S_WIN, S_LOSE} state_e;

    state_e                    state_q, state_d;
    logic [ID_W*NCELL-1:0]     map_q, map_d;
    logic [2*NCELL-1:0]        cell_q, cell_d;
    logic [CNT_W-1:0]          len_q [NID];
    logic [CNT_W-1:0]          len_d [NID];
    logic [CNT_W-1:0]          rem_q [NID];
    logic [CNT_W-1:0]          rem_d [NID];
    logic [TURN_W-1:0]         turns_q, turns_d;
    logic [ID_W-1:0]           ships_q, ships_d;
    logic [IDX_W-1:0]          sweep_idx_q, sweep_idx_d;
    logic [ID_W-1:0]           sweep_id_q, sweep_id_d;
    logic                      fire_prev_q;
    logic                      place_err_q, place_err_d;
    logic                      shot_valid_q, shot_valid_d;
    logic [1:0]                shot_code_q, shot_code_d;
    logic                      busy_q, game_over_q, win_q;

    logic                      fire_edge;
    logic                      place_ok;
    logic                      shot_in;
    int unsigned               p_idx, s_idx, k_idx;
    logic [ID_W-1:0]           p_map, s_map, k_map;
    logic [ID_W-1:0]           ship_cnt;

    // Next-state and result logic.
    always_comb begin
        state_d      = state_q;
        map_d        = map_q;
        cell_d       = cell_q;
        len_d        = len_q;
        rem_d        = rem_q;
        turns_d      = turns_q;
        ships_d      = ships_q;
        sweep_idx_d  = sweep_idx_q;
        sweep_id_d   = sweep_id_q;
        place_err_d  = 1'b0;
        shot_valid_d = 1'b0;
        shot_code_d  = 2'b00;

        fire_edge = bus.fire && !fire_prev_q;
        p_idx     = 32'(bus.place_row) * GRID_N + 32'(bus.place_col);
        s_idx     = 32'(bus.sprite_row) * GRID_N + 32'(bus.sprite_col);
        k_idx     = 32'(sweep_idx_q);
        shot_in   = (bus.sprite_row < GRID_N4) && (bus.sprite_col < GRID_N4);
        p_map     = ((bus.place_row < GRID_N4) && (bus.place_col < GRID_N4)) ?
                    map_q[p_idx*ID_W +: ID_W] : '0;
        s_map     = shot_in ? map_q[s_idx*ID_W +: ID_W] : '0;
        k_map     = map_q[k_idx*ID_W +: ID_W];
        place_ok  = (bus.place_row < GRID_N4) && (bus.place_col < GRID_N4) &&
                    (bus.place_id != '0) && (bus.place_id <= MAX_ID) && (p_map == '0);

        ship_cnt = '0;
        for (int unsigned i = 1; i <= MAX_SHIPS; i++) begin
            if (len_q[ID_W'(i)] != '0) ship_cnt = ship_cnt + ID_W'(1);
        end

        case (state_q)
            S_LOAD: begin
                if (bus.place_valid) begin
                    if (place_ok) begin
                        map_d[p_idx*ID_W +: ID_W] = bus.place_id;
                        if (len_q[bus.place_id] == '0) ships_d = ships_q + ID_W'(1);
                        len_d[bus.place_id] = len_q[bus.place_id] + CNT_W'(1);
                        rem_d[bus.place_id] = rem_q[bus.place_id] + CNT_W'(1);
                    end else begin
                        place_err_d = 1'b1;
                    end
                end
                if (bus.start && (ships_q != '0)) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (fire_edge) begin
                    shot_valid_d = 1'b1;
                    if (!shot_in || (cell_q[s_idx*2 +: 2] != 2'b00)) begin
                        shot_code_d = 2'b00;
                    end else if (s_map == '0) begin
                        cell_d[s_idx*2 +: 2] = 2'b01;
                        turns_d              = turns_q - TURN_W'(1);
                        shot_code_d          = 2'b01;
                        if (turns_q == TURN_W'(1)) state_d = S_LOSE;
                    end else if (rem_q[s_map] > CNT_W'(1)) begin
                        cell_d[s_idx*2 +: 2] = 2'b10;
                        rem_d[s_map]         = rem_q[s_map] - CNT_W'(1);
                        shot_code_d          = 2'b10;
                    end else begin
                        cell_d[s_idx*2 +: 2] = 2'b10;
                        rem_d[s_map]         = '0;
                        ships_d              = ships_q - ID_W'(1);
                        shot_code_d          = 2'b11;
                        sweep_id_d           = s_map;
                        sweep_idx_d          = '0;
                        state_d              = S_SWEEP;
                    end
                end
            end
            S_SWEEP: begin
                // One cell per cycle: promote the sunk ship's hit cells to sunk.
                if ((k_map == sweep_id_q) && (cell_q[k_idx*2 +: 2] == 2'b10)) begin
                    cell_d[k_idx*2 +: 2] = 2'b11;
                end
                if (sweep_idx_q == IDX_W'(NCELL - 1)) begin
                    state_d = (ships_q == '0) ? S_WIN : S_PLAY;
                end else begin
                    sweep_idx_d = sweep_idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase

        // Restart keeps the placement and overrides any same-cycle shot.
        if (bus.new_game && (state_q != S_LOAD)) begin
            cell_d       = '0;
            turns_d      = TURN_W'(TURNS);
            rem_d        = len_q;
            ships_d      = ship_cnt;
            sweep_idx_d  = '0;
            shot_valid_d = 1'b0;
            shot_code_d  = 2'b00;
            state_d      = S_PLAY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            map_q        <= '0;
            cell_q       <= '0;
            len_q        <= '{default: '0};
            rem_q        <= '{default: '0};
            turns_q      <= TURN_W'(TURNS);
            ships_q      <= '0;
            sweep_idx_q  <= '0;
            sweep_id_q   <= '0;
            fire_prev_q  <= 1'b0;
            place_err_q  <= 1'b0;
            shot_valid_q <= 1'b0;
            shot_code_q  <= 2'b00;
            busy_q       <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            map_q        <= map_d;
            cell_q       <= cell_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            turns_q      <= turns_d;
            ships_q      <= ships_d;
            sweep_idx_q  <= sweep_idx_d;
            sweep_id_q   <= sweep_id_d;
            fire_prev_q  <= bus.fire;
            place_err_q  <= place_err_d;
            shot_valid_q <= shot_valid_d;
            shot_code_q  <= shot_code_d;
            busy_q       <= (state_d == S_SWEEP);
            game_over_q  <= (state_d == S_WIN) || (state_d == S_LOSE);
            win_q        <= (state_d == S_WIN);
        end
    end

    assign bus.place_err        = place_err_q;
    assign bus.cell_status_flat = cell_q;
    assign bus.turns_left       = turns_q;
    assign bus.ships_left       = ships_q;
    assign bus.shot_valid       = shot_valid_q;
    assign bus.shot_code        = shot_code_q;
    assign bus.busy             = busy_q;
    assign bus.game_over        = game_over_q;
    assign bus.win              = win_q;
endmodule

// File: tb/tb_battleship_board.sv
// Bench for battleship_board on a 4x4 board with two ships and three misses.
module tb_battleship_board;
    localparam int unsigned GN = 4;
    localparam int unsigned MS = 2;
    localparam int unsigned IW = 2;
    localparam int unsigned TN = 3;
    localparam int unsigned TW = 2;
    localparam int unsigned NC = GN * GN;
    localparam int M_LOAD = 0, M_PLAY = 1, M_WIN = 2, M_LOSE = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    battleship_board_if #(.GRID_N(GN), .ID_W(IW), .TURN_W(TW)) bus ();

    battleship_board #(.GRID_N(GN), .MAX_SHIPS(MS), .ID_W(IW), .TURNS(TN), .TURN_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Game model: ship map, cell status, per-ship counts.
    int mmap [NC];
    int mstat[NC];
    int mlen [MS+1];
    int mrem [MS+1];
    int mturns, mships, mst;
    int total = 0;
    int bad   = 0;

    typedef struct {
        bit pv;
        int r;
        int c;
        int id;
        bit st;
        bit e_err;
        int e_ships;
    } lvec_t;
    lvec_t lv[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_flat();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) v[i*2 +: 2] = 2'(mstat[i]);
        return v;
    endfunction

    task automatic model_clear_map();
        for (int i = 0; i < NC; i++) begin mmap[i] = 0; mstat[i] = 0; end
        for (int i = 0; i <= MS; i++) begin mlen[i] = 0; mrem[i] = 0; end
        mturns = TN; mships = 0; mst = M_LOAD;
    endtask

    task automatic model_restart();
        for (int i = 0; i < NC; i++) mstat[i] = 0;
        for (int i = 0; i <= MS; i++) mlen[i] = 0;
        for (int i = 0; i < NC; i++) if (mmap[i] != 0) mlen[mmap[i]]++;
        mships = 0;
        for (int i = 1; i <= MS; i++) begin
            mrem[i] = mlen[i];
            if (mlen[i] != 0) mships++;
        end
        mturns = TN;
        mst    = M_PLAY;
    endtask

    // Returns -1 when the shot is not accepted at all.
    task automatic model_fire(input int r, input int c, output int code, output int sid);
        int i;
        sid = 0;
        if (mst != M_PLAY) begin code = -1; return; end
        if (r >= GN || c >= GN) begin code = 0; return; end
        i = r * GN + c;
        if (mstat[i] != 0) code = 0;
        else if (mmap[i] == 0) begin
            mstat[i] = 1; mturns--; code = 1;
            if (mturns == 0) mst = M_LOSE;
        end else begin
            mstat[i] = 2; mrem[mmap[i]]--;
            if (mrem[mmap[i]] == 0) begin mships--; code = 3; sid = mmap[i]; end
            else code = 2;
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_cells"}, bus.cell_status_flat, exp_flat());
        chk({tag, "_turns"}, bus.turns_left, mturns);
        chk({tag, "_ships"}, bus.ships_left, mships);
        chk({tag, "_over"}, bus.game_over, (mst == M_WIN || mst == M_LOSE));
        chk({tag, "_win"}, bus.win, (mst == M_WIN));
    endtask

    task automatic wait_sweep(input int sid, input bit inject);
        int n = 0;
        int sv = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            if (inject && n == 4) begin bus.sprite_row = 4'd2; bus.sprite_col = 4'd2; bus.fire = 1'b1; end
            if (inject && n == 6) bus.fire = 1'b0;
            step();
            n++;
            if (bus.shot_valid) sv++;
        end
        chk("busy_cycles", n, 16);
        chk("sweep_shots", sv, 0);
        for (int i = 0; i < NC; i++) if (mmap[i] == sid) mstat[i] = 3;
        mst = (mships == 0) ? M_WIN : M_PLAY;
        chk_state("post_sweep");
    endtask

    task automatic do_fire(input int r, input int c);
        int code, sid;
        model_fire(r, c, code, sid);
        bus.sprite_row = 4'(r);
        bus.sprite_col = 4'(c);
        bus.fire = 1'b1;
        step();
        if (code < 0) begin
            chk("ignored_shot", bus.shot_valid, 0);
            bus.fire = 1'b0;
            step();
            chk_state("ignored");
            return;
        end
        chk("shot_valid", bus.shot_valid, 1);
        chk("shot_code", bus.shot_code, code);
        chk("shot_cells", bus.cell_status_flat, exp_flat());
        chk("shot_turns", bus.turns_left, mturns);
        bus.fire = 1'b0;
        if (code == 3) begin
            chk("busy_start", bus.busy, 1);
            wait_sweep(sid, 1'b0);
        end else begin
            step();
            chk("pulse_end", bus.shot_valid, 0);
            chk_state("shot");
        end
    endtask

    task automatic do_new_game(input bit with_fire);
        bus.new_game = 1'b1;
        bus.fire = with_fire;
        bus.sprite_row = 4'd2;
        bus.sprite_col = 4'd2;
        step();
        bus.new_game = 1'b0;
        bus.fire = 1'b0;
        model_restart();
        chk("ng_shot", bus.shot_valid, 0);
        step();
        chk("ng_shot2", bus.shot_valid, 0);
        chk_state("new_game");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int code, sid;
        lv[0] = '{1'b0, 0, 0, 0, 1'b1, 1'b0, 0};
        lv[1] = '{1'b1, 0, 0, 1, 1'b0, 1'b0, 1};
        lv[2] = '{1'b1, 0, 1, 1, 1'b0, 1'b0, 1};
        lv[3] = '{1'b1, 0, 0, 2, 1'b0, 1'b1, 1};
        lv[4] = '{1'b1, 1, 1, 0, 1'b0, 1'b1, 1};
        lv[5] = '{1'b1, 1, 1, 3, 1'b0, 1'b1, 1};
        lv[6] = '{1'b1, 4, 0, 1, 1'b0, 1'b1, 1};
        lv[7] = '{1'b1, 0, 4, 1, 1'b0, 1'b1, 1};
        lv[8] = '{1'b1, 3, 3, 2, 1'b0, 1'b0, 2};

        bus.place_valid = 1'b0; bus.place_row = '0; bus.place_col = '0; bus.place_id = '0;
        bus.start = 1'b0; bus.new_game = 1'b0; bus.fire = 1'b0;
        bus.sprite_row = '0; bus.sprite_col = '0;
        reset = 1'b1;
        model_clear_map();
        step(); step();
        reset = 1'b0;
        chk_state("reset");
        chk("reset_busy", bus.busy, 0);
        chk("reset_err", bus.place_err, 0);

        // Placement table, including a start with nothing placed.
        foreach (lv[i]) begin
            bus.place_valid = lv[i].pv;
            bus.place_row   = 4'(lv[i].r);
            bus.place_col   = 4'(lv[i].c);
            bus.place_id    = IW'(lv[i].id);
            bus.start       = lv[i].st;
            step();
            bus.place_valid = 1'b0;
            bus.start       = 1'b0;
            chk($sformatf("place_err[%0d]", i), bus.place_err, lv[i].e_err);
            chk($sformatf("place_ships[%0d]", i), bus.ships_left, lv[i].e_ships);
            if (lv[i].pv && !lv[i].e_err) mmap[lv[i].r*GN + lv[i].c] = lv[i].id;
            if (i == 0) do_fire(0, 0);
        end
        mships = 2;
        step();
        chk("err_clear", bus.place_err, 0);

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        model_restart();
        chk_state("start");

        do_fire(0, 0);
        do_fire(0, 0);

        // Held button yields a single shot.
        model_fire(0, 0, code, sid);
        bus.sprite_row = 4'd0; bus.sprite_col = 4'd0; bus.fire = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin step(); if (bus.shot_valid) cnt++; end
        bus.fire = 1'b0;
        step();
        chk("held_fire_shots", cnt, 1);

        // Sink ship 1 with a discarded fire edge mid-sweep.
        model_fire(0, 1, code, sid);
        bus.sprite_row = 4'd0; bus.sprite_col = 4'd1; bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
        chk("sink_code", bus.shot_code, code);
        chk("sink_cells_pre", bus.cell_status_flat, exp_flat());
        wait_sweep(sid, 1'b1);

        do_fire(1, 0);
        do_fire(1, 1);
        do_fire(1, 2);
        do_fire(2, 2);
        do_new_game(1'b1);

        // Random shots against the model.
        for (int n = 0; n < 40 && mst == M_PLAY; n++) do_fire($urandom_range(0, GN), $urandom_range(0, GN));

        do_new_game(1'b0);
        do_fire(0, 0);
        do_fire(0, 1);
        do_fire(3, 3);
        do_fire(1, 0);

        // Reset in the middle of a sweep.
        do_new_game(1'b0);
        do_fire(0, 0);
        model_fire(0, 1, code, sid);
        bus.sprite_row = 4'd0; bus.sprite_col = 4'd1; bus.fire = 1'b1;
        step();
        bus.fire = 1'b0;
        chk("mid_busy", bus.busy, 1);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear_map();
        chk_state("mid_reset");
        chk("mid_reset_busy", bus.busy, 0);
        chk("mid_reset_shot", bus.shot_valid, 0);
        do_fire(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/battleship_board.md
Name: battleship_board

Overview:
- Parametrised successor to the fixed 10x10 game-state block.
- Grid size, ship count and turn budget are set by parameters; ship placement is loaded at run time over a placement port instead of being hard-coded.
- A run-time turn counter replaces the fixed 15-turn budget.
- Adds an explicit game FSM, per-ship sunk sweep, shot-result reporting, win/lose flags and a new-game restart that keeps the placement.
- Sits between the button/cursor logic and the VGA renderer; the renderer consumes cell_status_flat.

Parameters:
- GRID_N, 10, rows = cols of the board (2..15).
- MAX_SHIPS, 5, maximum distinct ship ids (ids 1..MAX_SHIPS).
- ID_W, 3, width of ship id; must satisfy 2^ID_W > MAX_SHIPS.
- TURNS, 15, misses allowed per game.
- TURN_W, 5, width of turns_left; must satisfy 2^TURN_W > TURNS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; full clear including ship map.
- place_valid  in  1  placement write strobe (LOAD state only).
- place_row  in  4  placement row.
- place_col  in  4  placement column.
- place_id  in  ID_W  ship id for the cell.
- start  in  1  LOAD -> PLAY.
- new_game  in  1  restart with the same placement.
- fire  in  1  button level; internally rising-edge detected.
- sprite_row  in  4  target row.
- sprite_col  in  4  target column.
- place_err  out  1  one-cycle pulse: rejected placement.
- cell_status_flat  out  2*GRID_N*GRID_N  cell (r,c) at bits [(r*GRID_N+c)*2 +: 2]; 00 unbombed, 01 miss, 10 hit, 11 sunk.
- turns_left  out  TURN_W  remaining misses.
- ships_left  out  ID_W  ids with unhit cells remaining.
- shot_valid  out  1  one-cycle pulse, result of an accepted fire.
- shot_code  out  2  00 repeat/out-of-range, 01 miss, 10 hit, 11 hit-and-sunk.
- busy  out  1  high in SWEEP.
- game_over  out  1  high in WIN or LOSE.
- win  out  1  high in WIN.

Behaviour:
- States: LOAD, PLAY, SWEEP, WIN, LOSE.
- Reset (any state, including mid-SWEEP):
  - state=LOAD; ship map all 0; ship_len[], remaining[] = 0.
  - All cells 00; turns_left=TURNS; ships_left=0.
  - All pulses 0; busy=0, game_over=0, win=0; fire edge register cleared.
- LOAD:
  - A place_valid write is accepted when row<GRID_N, col<GRID_N, 1<=id<=MAX_SHIPS and the map cell is 0.
  - Accepted write: map[r][c]<=id; ship_len[id]++ and remaining[id]++; ships_left increments when ship_len[id] goes 0->1.
  - Any other place_valid: no change, place_err=1 next cycle.
  - start with ships_left>0 -> PLAY; start with ships_left==0 is ignored.
  - fire is ignored in LOAD.
- PLAY, accepted fire = rising edge of fire (fire=1, previous fire=0):
  - Target outside the grid, or cell status !=00: no state change; shot_code=00.
  - Map==0: cell<=01; turns_left--; shot_code=01. If turns_left was 1 -> LOSE.
  - Map==id, remaining[id]>1: cell<=10; remaining[id]--; shot_code=10.
  - Map==id, remaining[id]==1: cell<=10; remaining[id]<=0; ships_left--; shot_code=11; latch sweep_id=id; -> SWEEP.
  - Result timing: shot_valid/shot_code appear and cell/turns update on the clock edge after the sampled cycle (latency 1).
  - Hits do not consume turns.
- SWEEP:
  - Index k runs 0..GRID_N*GRID_N-1, one cell per cycle.
  - Cell k with map==sweep_id and status 10 becomes 11.
  - Duration is exactly GRID_N*GRID_N cycles with busy=1. Fire edges during SWEEP are discarded, not queued.
  - After the last cell: ships_left==0 -> WIN, else -> PLAY.
- WIN/LOSE: terminal; fire ignored; board frozen.
- new_game, in PLAY/SWEEP/WIN/LOSE:
  - All cells 00; turns_left=TURNS; remaining[i]=ship_len[i]; ships_left = count of nonzero ship_len; sweep aborted; -> PLAY.
  - new_game outranks a same-cycle fire.
  - In LOAD, new_game is ignored.
- Priority: reset > new_game > start/place/fire.

Test Plan:
- GRID_N=4, MAX_SHIPS=2, TURNS=3. Place id1 at (0,0),(0,1); id2 at (3,3); start -> ships_left=2, turns_left=3, state PLAY, all cells 00.
- Place (0,0) again, and place id=0 -> place_err pulse each time; ship_len unchanged. start with nothing placed -> stays LOAD.
- Fire at (0,0): shot_code=10, cell0=10, turns_left=3. Fire again at (0,0): shot_code=00, no change. Fire held high for 5 cycles -> one shot only.
- Fire at (0,1): shot_code=11; busy high exactly 16 cycles; cells 0 and 1 read 10 until swept, then 11; a fire edge mid-sweep is ignored; ships_left=1 -> PLAY.
- Misses at (1,0),(1,1),(1,2): turns_left 2,1,0, then LOSE (game_over=1, win=0). new_game -> PLAY, turns_left=3, ships_left=2, all cells 00.
- Sink id1 and id2 -> WIN after the final 16-cycle sweep (win=1). Assert reset mid-sweep -> LOAD, all outputs at reset values.
